serial_adder_acc: RTL and testbench

- Bit-serial ripple adder that extends the combinational half-adder cell into a sequential full adder with a registered carry.
- Adds two WIDTH-bit operands one bit per cycle, LSB first.
- Sits directly downstream of the half-adder stage in the user-project top: it consumes per-bit sum/carry terms and produces a full WIDTH-bit sum and carry-out.
- Provides a start/busy/done handshake so the top can drive it from ui_in and present the result on uo_out.

---
 rtl/serial_add_pkg.sv | 23 ++
 rtl/serial_fa_cell.sv | 19 +
 rtl/serial_adder_acc.sv | 127 ++++++++++++
 tb/tb_serial_adder_acc.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding,
// default operand width and the bit-counter width function.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

  localparam int SA_WIDTH_DEFAULT = 8;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full-adder bit cell formed from two half-adder stages:
// the first combines the operand bits, the second folds in the carry.
module serial_fa_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g;

  assign p    = a_bit ^ b_bit;
  assign g    = a_bit & b_bit;
  assign s    = p ^ cin;
  assign cout = g | (p & cin);

endmodule

// File: rtl/serial_adder_acc.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first, one bit per
// enabled cycle, with a start/busy/done handshake and held result.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one result bit per enabled cycle, WIDTH cycles total
// DONE  | one enabled cycle with done=1; start here chains a new add
module serial_adder_acc
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             s_bit;
  logic             carry_d;
  logic [WIDTH-1:0] sum_sr_d;
  logic             last_step;
  logic             load;

  serial_fa_cell u_fa (
    .a_bit (a_sr_q[0]),
    .b_bit (b_sr_q[0]),
    .cin   (carry_q),
    .s     (s_bit),
    .cout  (carry_d)
  );

  // New bits enter at the MSB so that after WIDTH steps bit 0 lands at [0].
  assign sum_sr_d  = {s_bit, sum_sr_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CNT_LAST);
  assign load      = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= carry_d;
          sum_sr_q <= sum_sr_d;
          if (last_step) begin
            sum_q   <= sum_sr_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (load) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_acc.sv
// Self-checking bench for serial_adder_acc: directed corner cases plus
// randomized operands, stalls and back-to-back starts against a+b.
module tb_serial_adder_acc;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int vec_cnt;
  int miss_cnt;

  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_adder_acc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One addition. pre=1: start/operands were already driven by the caller
  // in the current cycle. chain=1: leave start high with na/nb in DONE.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int stall_at, input int stall_len,
                         input bit glitch, input bit pre,
                         input bit chain, input logic [W-1:0] na,
                         input logic [W-1:0] nb);
    logic [W:0] full;
    full = {1'b0, ta} + {1'b0, tb_v};
    if (!pre) begin
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int i = 1; i <= W + stall_len; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("sum_held", sum, exp_sum);
      chk("cout_held", cout, exp_cout);
      if (i == stall_at) ena = 1'b0;
      if (i == stall_at + stall_len) ena = 1'b1;
      if (glitch && i == 3) begin
        start = 1'b1; a = '1; b = '1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("sum_result", sum, exp_sum);
    chk("cout_result", cout, exp_cout);
    if (chain) begin
      a = na; b = nb; start = 1'b1;
    end else begin
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("busy_idle", busy, 0);
      chk("sum_idle", sum, exp_sum);
      chk("cout_idle", cout, exp_cout);
    end
  endtask

  logic [W-1:0] ca, cb, na, nb;
  bit           pre, ch;
  int           sa, sl;

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;

    run_txn(8'h35, 8'h0A, 0, 0, 0, 0, 0, '0, '0);
    run_txn(8'hFF, 8'h01, 0, 0, 0, 0, 0, '0, '0);
    run_txn(8'h80, 8'h80, 0, 0, 0, 0, 0, '0, '0);
    run_txn(8'h00, 8'h00, 0, 0, 0, 0, 0, '0, '0);
    run_txn(8'h12, 8'h34, 0, 0, 1, 0, 0, '0, '0);
    run_txn(8'h55, 8'hAA, 4, 3, 0, 0, 0, '0, '0);

    // Abort mid-run: reset must clear outputs without a clock edge.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("busy_pre_abort", busy, 1);
      if (i < 4) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    exp_sum  = '0;
    exp_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
      chk("post_abort_sum", sum, 0);
    end

    run_txn(8'h10, 8'h20, 0, 0, 0, 0, 1, 8'h01, 8'h02);
    run_txn(8'h01, 8'h02, 0, 0, 0, 1, 0, '0, '0);

    pre = 1'b0;
    ca = W'($urandom);
    cb = W'($urandom);
    for (int n = 0; n < 24; n++) begin
      ch = (n < 23) && ($urandom_range(0, 3) == 0);
      na = W'($urandom);
      nb = W'($urandom);
      sa = $urandom_range(1, W - 1);
      sl = $urandom_range(0, 3);
      run_txn(ca, cb, sa, sl, 0, pre, ch, na, nb);
      pre = ch;
      ca = na;
      cb = nb;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
